imm_extend_stage: RTL
=====================

# imm_extend_stage

Registered, parametrised immediate-extension stage for the RISC-V decode path. It accepts a 32-bit instruction word and an immediate-format select, produces the XLEN-wide sign/zero-extended immediate one cycle later, and carries a sideband tag. A valid/ready handshake with a 2-entry skid buffer sustains full throughput and absorbs execute-stage stalls. It also supports flush, adds three formats (U shifted into place, CSR zimm, shift amount), and reports an illegal-select error instead of driving X.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAGW, 5, sideband tag width carried alongside each immediate (e.g. rd or ROB index).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  stage can accept; registered, not combinationally dependent on out_ready.
- in_instr  in  32  instruction word.
- in_immsrc  in  3  format select.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_immext  out  XLEN  extended immediate.
- out_err  out  1  in_immsrc was illegal for this entry.
- out_tag  out  TAGW  tag of output entry.

## Operation
- Format select (sx = sign-extend from instr[31] to XLEN; zx = zero-extend):
  - 000 I: sx(instr[31:20]).
  - 001 S: sx({instr[31:25], instr[11:7]}).
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sx({instr[31:12], 12'b0}). The upper immediate is placed in bits 31:12.
  - 101 Z: zx(instr[19:15]) (CSR zimm).
  - 110 SH: zx(instr[25:20]) when XLEN=64; zx(instr[24:20]) when XLEN=32.
  - 111: immext = 0, err = 1.
- Extension is computed combinationally on the input side. Only registered values reach the outputs.
- Transfer occurs on in_valid&in_ready (accept) or out_valid&out_ready (drain).
- Buffer state: EMPTY (0 entries), ONE (main only), FULL (main+skid).
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> FULL. Drain without accept -> EMPTY. Accept and drain together -> ONE, with main replaced by the new entry.
  - FULL: drain -> ONE, with skid moved to main. No accept is possible because in_ready=0.
- in_ready = (state != FULL).
- Entries leave in strict FIFO order.

## Timing
- Latency: an entry accepted at edge N is presented at out_* from edge N+1 when the buffer was empty.
- Throughput: 1 entry/cycle with out_ready held high.
- Reset values: out_valid=0, out_immext=0, out_err=0, out_tag=0, in_ready=1, state=EMPTY.
- Reset mid-operation: all entries are dropped at the next edge. Inputs are ignored during reset cycles.
- flush: at the next edge the state becomes EMPTY, out_valid=0 and in_ready=1. An in_valid presented in the flush cycle is discarded. Reset has priority over flush.
- out_* hold stable while out_valid=1 and out_ready=0.
- A change of out_ready never changes in_ready in the same cycle.

## Structure
- Package imm_pkg holds the immsrc constants IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH and IMM_BAD (000..111).
- Sub-module imm_gen is purely combinational (instr, immsrc -> immext, err), parametrised by XLEN.
- The top level contains the 2-entry skid buffer and the state register.

## Test plan
- XLEN=32, I-format: instr 0xFFF00093, immsrc 000 -> out_immext 0xFFFFFFFF, out_err 0, one cycle after accept. With XLEN=64 the same stimulus -> 0xFFFFFFFFFFFFFFFF.
- U and J formats: instr 0x000153B7, immsrc 100 -> 0x00015000. Instr 0xFFDFF06F, immsrc 011 -> 0xFFFFFFFC.
- B format and illegal select: instr 0x00000463, immsrc 010 -> 0x00000008. Immsrc 111 -> immext 0, err 1.
- Backpressure: stream tags 1,2,3 with out_ready=0 for 3 cycles.
  - in_ready drops after tags 1 and 2 are accepted; tag 3 is held by the producer.
  - After out_ready=1, tags emerge in order 1,2,3 with no loss or duplication.
- Flush while FULL: next cycle out_valid=0 and in_ready=1. The in_valid presented with flush never appears at the output.
- Reset mid-stream with out_valid=1: the next cycle has all outputs at their reset values. The first post-reset accept appears 1 cycle later.

Source files
------------

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate-format select encodings and skid-buffer state type
//               shared by the immediate-extension stage.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Immediate-format select encodings (in_immsrc)
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_BAD = 3'b111;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RISC-V immediate decoder. Selects the immediate
//               field by format, sign- or zero-extends it to XLEN and flags an
//               illegal format select.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            err
);

    // Shift-amount field is one bit wider on RV64
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic [XLEN-1:0] sign_fill;
    logic            unused_opcode;

    assign sign_fill     = {XLEN{instr[31]}};
    // The opcode field never contributes to an immediate
    assign unused_opcode = ^instr[6:0];

    // Start from the fill pattern, then overlay the format's field bits
    always_comb begin
        immext = '0;
        err    = 1'b0;
        case (immsrc)
            IMM_I: begin
                immext       = sign_fill;
                immext[11:0] = instr[31:20];
            end
            IMM_S: begin
                immext       = sign_fill;
                immext[11:0] = {instr[31:25], instr[11:7]};
            end
            IMM_B: begin
                immext       = sign_fill;
                immext[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            IMM_J: begin
                immext       = sign_fill;
                immext[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            IMM_U: begin
                immext       = sign_fill;
                immext[31:0] = {instr[31:12], 12'b0};
            end
            IMM_Z: begin
                immext[4:0] = instr[19:15];
            end
            IMM_SH: begin
                immext[SHW-1:0] = instr[20 +: SHW];
            end
            default: begin
                // Illegal select: drive a defined zero and raise the error flag
                err = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_stage
// Description : Registered immediate-extension stage. Decodes the immediate on
//               the input side and holds results in a two-entry skid buffer
//               (main + skid) behind a valid/ready handshake, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_immext,
    output logic            out_err,
    output logic [TAGW-1:0] out_tag
);

    buf_state_e      state;
    buf_state_e      state_next;

    logic [XLEN-1:0] gen_imm;
    logic            gen_err;

    logic [XLEN-1:0] main_imm;
    logic            main_err;
    logic [TAGW-1:0] main_tag;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;
    logic [TAGW-1:0] skid_tag;

    logic            accept;
    logic            drain;
    logic            load_main_new;
    logic            load_skid;
    logic            main_from_skid;

    imm_gen #(
        .XLEN   (XLEN)
    ) u_imm_gen (
        .instr  (in_instr),
        .immsrc (in_immsrc),
        .immext (gen_imm),
        .err    (gen_err)
    );

    // Handshake flags decode only the state register, so in_ready never
    // follows out_ready combinationally.
    assign in_ready   = (state != BUF_FULL);
    assign out_valid  = (state != BUF_EMPTY);
    assign accept     = in_valid & in_ready;
    assign drain      = out_valid & out_ready;

    assign out_immext = main_imm;
    assign out_err    = main_err;
    assign out_tag    = main_tag;

    // Next-state and buffer-load decisions
    always_comb begin
        state_next     = state;
        load_main_new  = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    state_next    = BUF_ONE;
                    load_main_new = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && !drain) begin
                    state_next = BUF_FULL;
                    load_skid  = 1'b1;
                end else if (!accept && drain) begin
                    state_next = BUF_EMPTY;
                end else if (accept && drain) begin
                    // Main leaves while the new entry takes its place
                    load_main_new = 1'b1;
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    state_next     = BUF_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    // State register; reset outranks flush, both empty the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUF_EMPTY;
        end else if (flush) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Buffer entry registers; a flush cycle loads nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            main_imm <= '0;
            main_err <= 1'b0;
            main_tag <= '0;
            skid_imm <= '0;
            skid_err <= 1'b0;
            skid_tag <= '0;
        end else if (!flush) begin
            if (load_main_new) begin
                main_imm <= gen_imm;
                main_err <= gen_err;
                main_tag <= in_tag;
            end else if (main_from_skid) begin
                main_imm <= skid_imm;
                main_err <= skid_err;
                main_tag <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= gen_imm;
                skid_err <= gen_err;
                skid_tag <= in_tag;
            end
        end
    end

endmodule
`default_nettype wire
